// File: rtl/quad_pe_seq.sv
// Sequencer for a 4-wide MAC processing element: streams IFM/weight reads,
// frames accumulations with pe_en/pe_finish and writes results to the OFM buffer.
module quad_pe_seq #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_num_steps,
  input  logic [CNT_W-1:0]  cfg_num_outputs,
  input  logic [ADDR_W-1:0] cfg_ifm_base,
  input  logic [ADDR_W-1:0] cfg_wgt_base,
  input  logic [ADDR_W-1:0] cfg_ofm_base,
  output logic              ifm_rd_en,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              pe_en,
  output logic              pe_finish,
  input  logic              pe_valid,
  output logic              ofm_wr_en,
  output logic [ADDR_W-1:0] ofm_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  num_steps_q;
  logic [CNT_W-1:0]  num_outputs_q;
  logic [ADDR_W-1:0] wgt_base_q;
  logic [CNT_W-1:0]  step_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              last_step;
  logic              last_out;
  logic              drain_done;

  assign ifm_rd_en = (state == FETCH);
  assign wgt_rd_en = (state == FETCH);
  assign busy      = (state != IDLE);
  assign ofm_wr_en = pe_valid && busy;

  assign last_step  = (step_cnt == num_steps_q - CNT_W'(1));
  assign last_out   = (out_cnt == num_outputs_q - CNT_W'(1));
  // The final result may land this cycle or may already have been counted.
  assign drain_done = (ofm_wr_en && (wr_cnt == num_outputs_q - CNT_W'(1))) ||
                      (wr_cnt == num_outputs_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      num_steps_q   <= '0;
      num_outputs_q <= '0;
      wgt_base_q    <= '0;
      step_cnt      <= '0;
      out_cnt       <= '0;
      wr_cnt        <= '0;
      ifm_addr      <= '0;
      wgt_addr      <= '0;
      ofm_addr      <= '0;
      pe_en         <= 1'b0;
      pe_finish     <= 1'b0;
      done          <= 1'b0;
    end else begin
      pe_en     <= 1'b0;
      pe_finish <= 1'b0;
      done      <= 1'b0;

      if (ofm_wr_en) begin
        wr_cnt   <= wr_cnt + CNT_W'(1);
        ofm_addr <= ofm_addr + ADDR_W'(1);
      end

      if (abort && (state != IDLE)) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if ((cfg_num_steps != '0) && (cfg_num_outputs != '0)) begin
                num_steps_q   <= cfg_num_steps;
                num_outputs_q <= cfg_num_outputs;
                wgt_base_q    <= cfg_wgt_base;
                ifm_addr      <= cfg_ifm_base;
                wgt_addr      <= cfg_wgt_base;
                ofm_addr      <= cfg_ofm_base;
                step_cnt      <= '0;
                out_cnt       <= '0;
                wr_cnt        <= '0;
                state         <= FETCH;
              end else begin
                done <= 1'b1;
              end
            end
          end
          FETCH: begin
            // PE framing strobes trail the read by one cycle to meet the returned data.
            pe_en     <= (step_cnt == '0);
            pe_finish <= last_step;
            ifm_addr  <= ifm_addr + ADDR_W'(1);
            if (last_step) begin
              step_cnt <= '0;
              wgt_addr <= wgt_base_q;
              out_cnt  <= out_cnt + CNT_W'(1);
              if (last_out) begin
                state <= DRAIN;
              end
            end else begin
              step_cnt <= step_cnt + CNT_W'(1);
              wgt_addr <= wgt_addr + ADDR_W'(1);
            end
          end
          DRAIN: begin
            if (drain_done) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_pe_seq.sv
// Self-checking bench for quad_pe_seq: directed corner jobs plus random jobs,
// compared cycle by cycle against a closed-form schedule of reads, PE strobes and writes.
module tb_quad_pe_seq;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  cfg_num_steps;
  logic [CNT_W-1:0]  cfg_num_outputs;
  logic [ADDR_W-1:0] cfg_ifm_base;
  logic [ADDR_W-1:0] cfg_wgt_base;
  logic [ADDR_W-1:0] cfg_ofm_base;
  logic              ifm_rd_en;
  logic              wgt_rd_en;
  logic [ADDR_W-1:0] ifm_addr;
  logic [ADDR_W-1:0] wgt_addr;
  logic              pe_en;
  logic              pe_finish;
  logic              pe_valid;
  logic              ofm_wr_en;
  logic [ADDR_W-1:0] ofm_addr;
  logic              busy;
  logic              done;
  logic              extra_valid;
  logic              fin_d;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Stand-in PE: result valid one cycle after the last group of an output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fin_d <= 1'b0;
    else          fin_d <= pe_finish;
  end
  assign pe_valid = fin_d | extra_valid;

  quad_pe_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_num_steps(cfg_num_steps), .cfg_num_outputs(cfg_num_outputs),
    .cfg_ifm_base(cfg_ifm_base), .cfg_wgt_base(cfg_wgt_base), .cfg_ofm_base(cfg_ofm_base),
    .ifm_rd_en(ifm_rd_en), .wgt_rd_en(wgt_rd_en), .ifm_addr(ifm_addr), .wgt_addr(wgt_addr),
    .pe_en(pe_en), .pe_finish(pe_finish), .pe_valid(pe_valid),
    .ofm_wr_en(ofm_wr_en), .ofm_addr(ofm_addr), .busy(busy), .done(done)
  );

  task automatic check_output(input string tag, input int cyc,
                              input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_rd"},    0, {30'd0, ifm_rd_en, wgt_rd_en}, 32'd0);
    check_output({tag, "_pe"},    0, {30'd0, pe_en, pe_finish}, 32'd0);
    check_output({tag, "_wr"},    0, {31'd0, ofm_wr_en}, 32'd0);
    check_output({tag, "_bsy"},   0, {30'd0, busy, done}, 32'd0);
    check_output({tag, "_addr"},  0, {ifm_addr[7:0], wgt_addr, ofm_addr}, 32'd0);
  endtask

  // Launch one job and check every cycle until well after it should have ended.
  task automatic apply_stimulus(input int steps, input int outputs,
                                input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] wb,
                                input logic [ADDR_W-1:0] ob,
                                input int abort_at, input bit restart_busy);
    int n;
    int last;
    int busy_cnt;
    int exp_busy_cnt;
    bit act;
    bit e_rd, e_en, e_fin, e_wr, e_busy, e_done;
    logic [ADDR_W-1:0] e_ifm, e_wgt, e_ofm;
    n        = steps * outputs;
    last     = (n == 0) ? 3 : n + 5;
    busy_cnt = 0;
    cfg_num_steps   = CNT_W'(steps);
    cfg_num_outputs = CNT_W'(outputs);
    cfg_ifm_base    = ib;
    cfg_wgt_base    = wb;
    cfg_ofm_base    = ob;
    start           = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      act = (abort_at == 0) || (c <= abort_at);
      e_ifm = ib + ADDR_W'(c - 1);
      e_wgt = wb;
      e_ofm = ob;
      if (n == 0) begin
        e_rd = 0; e_en = 0; e_fin = 0; e_wr = 0; e_busy = 0;
        e_done = (c == 1);
      end else begin
        e_rd   = act && (c <= n);
        e_en   = act && (c >= 2) && (c <= n + 1) && (((c - 2) % steps) == 0);
        e_fin  = act && (c >= 2) && (c <= n + 1) && (((c - 2) % steps) == steps - 1);
        e_wr   = act && (c >= 3) && (c <= n + 2) && (((c - 3) % steps) == steps - 1);
        e_busy = act && (c <= n + 3);
        e_done = act && (c == n + 3);
        e_wgt  = wb + ADDR_W'((c - 1) % steps);
        if (c >= 3) e_ofm = ob + ADDR_W'((c - 3) / steps);
      end
      if (busy) busy_cnt++;
      check_output("ifm_rd_en", c, {31'd0, ifm_rd_en}, {31'd0, e_rd});
      check_output("wgt_rd_en", c, {31'd0, wgt_rd_en}, {31'd0, e_rd});
      if (e_rd) begin
        check_output("ifm_addr", c, {20'd0, ifm_addr}, {20'd0, e_ifm});
        check_output("wgt_addr", c, {20'd0, wgt_addr}, {20'd0, e_wgt});
      end
      check_output("pe_en",     c, {31'd0, pe_en},     {31'd0, e_en});
      check_output("pe_finish", c, {31'd0, pe_finish}, {31'd0, e_fin});
      check_output("ofm_wr_en", c, {31'd0, ofm_wr_en}, {31'd0, e_wr});
      if (e_wr) check_output("ofm_addr", c, {20'd0, ofm_addr}, {20'd0, e_ofm});
      check_output("busy", c, {31'd0, busy}, {31'd0, e_busy});
      check_output("done", c, {31'd0, done}, {31'd0, e_done});
      start = restart_busy && (c == 2);
      abort = (abort_at != 0) && (c == abort_at);
      if (c == 1) begin
        cfg_num_steps   = CNT_W'($urandom);
        cfg_num_outputs = CNT_W'($urandom);
        cfg_ifm_base    = ADDR_W'($urandom);
        cfg_wgt_base    = ADDR_W'($urandom);
        cfg_ofm_base    = ADDR_W'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (n == 0)             exp_busy_cnt = 0;
    else if (abort_at != 0) exp_busy_cnt = abort_at;
    else                    exp_busy_cnt = n + 3;
    check_output("busy_total", last, busy_cnt, exp_busy_cnt);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; extra_valid = 1'b0;
    cfg_num_steps = '0; cfg_num_outputs = '0;
    cfg_ifm_base = '0; cfg_wgt_base = '0; cfg_ofm_base = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic job steps=3 outputs=2");
    apply_stimulus(3, 2, 12'h010, 12'h100, 12'h200, 0, 0);
    $display("[TB] single-step job");
    apply_stimulus(1, 4, 12'h040, 12'h0A0, 12'h300, 0, 0);
    $display("[TB] zero-count starts");
    apply_stimulus(0, 5, 12'h000, 12'h000, 12'h000, 0, 0);
    apply_stimulus(3, 0, 12'h000, 12'h000, 12'h000, 0, 0);
    $display("[TB] ifm address wrap");
    apply_stimulus(4, 1, 12'hFFE, 12'hFFF, 12'hFFF, 0, 0);
    $display("[TB] abort then rerun");
    apply_stimulus(3, 2, 12'h010, 12'h100, 12'h200, 3, 0);
    apply_stimulus(2, 3, 12'h123, 12'h456, 12'h789, 0, 0);
    $display("[TB] start while busy");
    apply_stimulus(2, 3, 12'h020, 12'h030, 12'h040, 0, 1);

    $display("[TB] reset during drain");
    cfg_num_steps = CNT_W'(2); cfg_num_outputs = CNT_W'(2);
    cfg_ifm_base = 12'h111; cfg_wgt_base = 12'h222; cfg_ofm_base = 12'h333;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_output("drain_busy", 5, {31'd0, busy}, 32'd1);
    check_output("drain_ifm_rd", 5, {31'd0, ifm_rd_en}, 32'd0);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_output("post_reset_busy", 0, {31'd0, busy}, 32'd0);
      check_output("post_reset_rd", 0, {31'd0, ifm_rd_en}, 32'd0);
    end

    $display("[TB] pe_valid while idle");
    extra_valid = 1'b1;
    #1 check_output("idle_valid_wr", 0, {31'd0, ofm_wr_en}, 32'd0);
    @(negedge clk);
    check_output("idle_valid_busy", 0, {31'd0, busy}, 32'd0);
    extra_valid = 1'b0;

    $display("[TB] random jobs");
    for (int j = 0; j < 8; j++) begin
      apply_stimulus(int'($urandom_range(5, 1)), int'($urandom_range(4, 1)),
                     ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
                     0, bit'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
